// File: rtl/serializer_pkg.sv
// Shared geometry and types for the 32-lane to 4-lane vector serializer.
package serializer_pkg;
    localparam int LANES     = 32;
    localparam int WIDTH     = 18;
    localparam int OUT_LANES = 4;
    localparam int BEATS     = 8;
    localparam int BEAT_W    = 3;

    typedef logic [WIDTH-1:0] lane_t;
    typedef lane_t [LANES-1:0] lane_vec_t;
    typedef lane_t [BEATS-1:0] beat_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;
endpackage

// File: rtl/lane_mux_18_8.sv
// Purpose: 8:1 selector of 18-bit lanes, one per serializer output lane.
// Latency: combinational.
// Backpressure: none; pure datapath.
module lane_mux_18_8
    import serializer_pkg::*;
(
    input  logic [BEAT_W-1:0] sel,
    input  beat_sel_t         data,
    output lane_t             y
);
    assign y = data[sel];
endmodule

// File: rtl/vector_serializer_18_32_4.sv
// Purpose: captures a 32x18 vector and emits it as eight 4-lane beats.
// Latency: first beat one cycle after acceptance; one vector per 8 cycles sustained.
// Backpressure: out_ready low holds the current beat; in_ready only opens on the last beat handshake.
module vector_serializer_18_32_4
    import serializer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_0,
    input  logic [WIDTH-1:0]  in_1,
    input  logic [WIDTH-1:0]  in_2,
    input  logic [WIDTH-1:0]  in_3,
    input  logic [WIDTH-1:0]  in_4,
    input  logic [WIDTH-1:0]  in_5,
    input  logic [WIDTH-1:0]  in_6,
    input  logic [WIDTH-1:0]  in_7,
    input  logic [WIDTH-1:0]  in_8,
    input  logic [WIDTH-1:0]  in_9,
    input  logic [WIDTH-1:0]  in_10,
    input  logic [WIDTH-1:0]  in_11,
    input  logic [WIDTH-1:0]  in_12,
    input  logic [WIDTH-1:0]  in_13,
    input  logic [WIDTH-1:0]  in_14,
    input  logic [WIDTH-1:0]  in_15,
    input  logic [WIDTH-1:0]  in_16,
    input  logic [WIDTH-1:0]  in_17,
    input  logic [WIDTH-1:0]  in_18,
    input  logic [WIDTH-1:0]  in_19,
    input  logic [WIDTH-1:0]  in_20,
    input  logic [WIDTH-1:0]  in_21,
    input  logic [WIDTH-1:0]  in_22,
    input  logic [WIDTH-1:0]  in_23,
    input  logic [WIDTH-1:0]  in_24,
    input  logic [WIDTH-1:0]  in_25,
    input  logic [WIDTH-1:0]  in_26,
    input  logic [WIDTH-1:0]  in_27,
    input  logic [WIDTH-1:0]  in_28,
    input  logic [WIDTH-1:0]  in_29,
    input  logic [WIDTH-1:0]  in_30,
    input  logic [WIDTH-1:0]  in_31,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_0,
    output logic [WIDTH-1:0]  out_1,
    output logic [WIDTH-1:0]  out_2,
    output logic [WIDTH-1:0]  out_3,
    output logic [BEAT_W-1:0] out_beat,
    output logic              out_last
);
    lane_vec_t         in_vec;
    lane_vec_t         buffer;
    state_t            state, state_n;
    logic [BEAT_W-1:0] beat, beat_n;
    logic              load;
    logic              last_beat;
    lane_t             mux_y [OUT_LANES];

    assign in_vec = {in_31, in_30, in_29, in_28, in_27, in_26, in_25, in_24,
                     in_23, in_22, in_21, in_20, in_19, in_18, in_17, in_16,
                     in_15, in_14, in_13, in_12, in_11, in_10, in_9,  in_8,
                     in_7,  in_6,  in_5,  in_4,  in_3,  in_2,  in_1,  in_0};

    assign last_beat = (beat == BEAT_W'(BEATS - 1));
    // Only out_ready feeds in_ready combinationally; in_valid never does.
    assign in_ready  = (state == IDLE) || ((state == SEND) && last_beat && out_ready);
    assign out_valid = (state == SEND);

    always_comb begin
        state_n = state;
        beat_n  = beat;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    beat_n  = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    if (last_beat) begin
                        beat_n = '0;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        beat_n = beat + 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                beat_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            beat   <= '0;
            buffer <= '0;
        end else begin
            state <= state_n;
            beat  <= beat_n;
            if (load) begin
                buffer <= in_vec;
            end
        end
    end

    // Output lane k on beat b carries buffer element 4*b + k.
    for (genvar k = 0; k < OUT_LANES; k++) begin : g_lane
        beat_sel_t sel_in;
        for (genvar b = 0; b < BEATS; b++) begin : g_beat
            assign sel_in[b] = buffer[OUT_LANES*b + k];
        end
        lane_mux_18_8 u_mux (
            .sel  (beat),
            .data (sel_in),
            .y    (mux_y[k])
        );
    end

    assign out_0    = out_valid ? mux_y[0] : '0;
    assign out_1    = out_valid ? mux_y[1] : '0;
    assign out_2    = out_valid ? mux_y[2] : '0;
    assign out_3    = out_valid ? mux_y[3] : '0;
    assign out_beat = out_valid ? beat : '0;
    assign out_last = out_valid && last_beat;
endmodule

// File: doc/vector_serializer_18_32_4.md
VECTOR_SERIALIZER_18_32_4 -- requirements
Module: vector_serializer_18_32_4

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock for all state.
REQ-002 SHALL have ports: reset input 1; reset is synchronous and active-high on clock clk.
REQ-003 SHALL have ports: in_valid input 1, a 32-lane vector is presented.
REQ-004 SHALL have ports: in_ready output 1, the block accepts the vector this cycle.
REQ-005 SHALL have ports: in_0 .. in_31 input 18 each, vector lanes (two's complement, passed unmodified).
REQ-006 SHALL have ports: out_valid output 1, a 4-lane beat is presented.
REQ-007 SHALL have ports: out_ready input 1, the consumer accepts the beat.
REQ-008 SHALL have ports: out_0 .. out_3 output 18 each, beat lanes.
REQ-009 SHALL have ports: out_beat output 3, beat index 0..7.
REQ-010 SHALL have ports: out_last output 1, high when out_beat==7 and out_valid.

Function
REQ-011 SHALL implement FSM with states IDLE and SEND, plus a 3-bit beat counter and a 32x18 capture buffer.
REQ-012 SHALL drive in_ready = (state==IDLE) OR (state==SEND AND beat==7 AND out_ready); combinational path from out_ready to in_ready only.
REQ-013 SHALL, on in_valid AND in_ready, capture in_0..in_31 into the buffer, set beat=0 and enter SEND on the next cycle.
REQ-014 SHALL drive out_valid high exactly when state==SEND.
REQ-015 SHALL drive out_k = buffer[4*beat + k] (k=0..3) and out_beat = beat while out_valid; all of out_0..out_3, out_beat, out_last SHALL be 0 while out_valid is low.
REQ-016 SHALL advance beat by 1 on out_valid AND out_ready when beat<7; hold all outputs stable while out_valid AND NOT out_ready.
REQ-017 SHALL, on the beat-7 handshake, return to IDLE if in_valid is low, or reload the buffer, set beat=0 and remain in SEND if in_valid is high (zero-bubble back-to-back vectors).
REQ-018 SHALL produce the first beat one cycle after input acceptance; sustained throughput is one vector per 8 cycles with out_ready held high.
REQ-019 SHALL NOT modify buffer contents while in SEND except through REQ-017.
REQ-020 SHALL ignore in_0..in_31 when in_valid AND in_ready is false.

Reset
REQ-021 SHALL, when reset is high at a clk edge, set state=IDLE, beat=0 and buffer=0, overriding any simultaneous handshake.
REQ-022 SHALL present after reset: in_ready=1, out_valid=0, out_0..out_3=0, out_beat=0, out_last=0.
REQ-023 SHALL discard a vector partially sent when reset asserts mid-operation; no beats of it appear after reset.

Structure
REQ-024 SHALL take LANES=32, WIDTH=18, OUT_LANES=4 and BEATS=8 from the shared package serializer_pkg, with the lane-vector type defined there.
REQ-025 SHALL instantiate one sub-module, lane_mux_18_8, an 8:1 18-bit selector used once per output lane.

Verification
REQ-026 SHALL cover reset-only: after reset, in_ready=1, out_valid=0 and all outputs 0.
REQ-027 SHALL cover single vector with lane i = i+1 and out_ready held high: beats 0..7 on consecutive cycles; beat 2 shows out_0..out_3 = 9,10,11,12; out_last only on beat 7.
REQ-028 SHALL cover backpressure: out_ready low for 3 cycles during beat 4; outputs held at 17..20 and in_ready=0 throughout.
REQ-029 SHALL cover back-to-back vectors A (lane=i) and B (lane=100+i) with in_valid high: B beat 0 (100..103) follows A beat 7 (28..31) with no idle cycle.
REQ-030 SHALL cover reset asserted at beat 3: next cycle out_valid=0 and in_ready=1; the next accepted vector starts at beat 0.
REQ-031 SHALL cover negative values (lane = -131072 = 0x20000) passing through bit-exact.
